// File: rtl/axi_host_arbiter.sv
// Grants one of NumHosts AXI hosts the bridge port for a whole transaction; AXI_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: host request seen in Idle at N gives device valid at N+1; one bubble cycle between transactions.
// Backpressure: device readies pass straight to the owner; all other hosts see ready/valid 0 and stall.
module axi_host_arbiter #(
    parameter int unsigned NumHosts  = 2,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned AddrWidth = 56,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned OwnerW   = $clog2(NumHosts),
    localparam int unsigned StrbW    = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumHosts-1:0]                 host_ar_valid_i,
    output logic [NumHosts-1:0]                 host_ar_ready_o,
    input  logic [NumHosts-1:0][IdWidth-1:0]    host_ar_id_i,
    input  logic [NumHosts-1:0][AddrWidth-1:0]  host_ar_addr_i,
    input  logic [NumHosts-1:0][7:0]            host_ar_len_i,
    input  logic [NumHosts-1:0][2:0]            host_ar_size_i,
    input  logic [NumHosts-1:0][1:0]            host_ar_burst_i,
    input  logic [NumHosts-1:0]                 host_aw_valid_i,
    output logic [NumHosts-1:0]                 host_aw_ready_o,
    input  logic [NumHosts-1:0][IdWidth-1:0]    host_aw_id_i,
    input  logic [NumHosts-1:0][AddrWidth-1:0]  host_aw_addr_i,
    input  logic [NumHosts-1:0][7:0]            host_aw_len_i,
    input  logic [NumHosts-1:0][2:0]            host_aw_size_i,
    input  logic [NumHosts-1:0][1:0]            host_aw_burst_i,
    input  logic [NumHosts-1:0]                 host_w_valid_i,
    output logic [NumHosts-1:0]                 host_w_ready_o,
    input  logic [NumHosts-1:0][DataWidth-1:0]  host_w_data_i,
    input  logic [NumHosts-1:0][StrbW-1:0]      host_w_strb_i,
    input  logic [NumHosts-1:0]                 host_w_last_i,
    output logic [NumHosts-1:0]                 host_r_valid_o,
    input  logic [NumHosts-1:0]                 host_r_ready_i,
    output logic [IdWidth-1:0]                  host_r_id_o,
    output logic [DataWidth-1:0]                host_r_data_o,
    output logic [1:0]                          host_r_resp_o,
    output logic                                host_r_last_o,
    output logic                                host_r_user_o,
    output logic [NumHosts-1:0]                 host_b_valid_o,
    input  logic [NumHosts-1:0]                 host_b_ready_i,
    output logic [IdWidth-1:0]                  host_b_id_o,
    output logic [1:0]                          host_b_resp_o,
    output logic                                host_b_user_o,
    output logic                                device_ar_valid_o,
    input  logic                                device_ar_ready_i,
    output logic [IdWidth-1:0]                  device_ar_id_o,
    output logic [AddrWidth-1:0]                device_ar_addr_o,
    output logic [7:0]                          device_ar_len_o,
    output logic [2:0]                          device_ar_size_o,
    output logic [1:0]                          device_ar_burst_o,
    output logic                                device_aw_valid_o,
    input  logic                                device_aw_ready_i,
    output logic [IdWidth-1:0]                  device_aw_id_o,
    output logic [AddrWidth-1:0]                device_aw_addr_o,
    output logic [7:0]                          device_aw_len_o,
    output logic [2:0]                          device_aw_size_o,
    output logic [1:0]                          device_aw_burst_o,
    output logic                                device_w_valid_o,
    input  logic                                device_w_ready_i,
    output logic [DataWidth-1:0]                device_w_data_o,
    output logic [StrbW-1:0]                    device_w_strb_o,
    output logic                                device_w_last_o,
    input  logic                                device_r_valid_i,
    output logic                                device_r_ready_o,
    input  logic [IdWidth-1:0]                  device_r_id_i,
    input  logic [DataWidth-1:0]                device_r_data_i,
    input  logic [1:0]                          device_r_resp_i,
    input  logic                                device_r_last_i,
    input  logic                                device_b_valid_i,
    output logic                                device_b_ready_o,
    input  logic [IdWidth-1:0]                  device_b_id_i,
    input  logic [1:0]                          device_b_resp_i,
    output logic                                busy_o,
    output logic [OwnerW-1:0]                   owner_o
);

    typedef enum logic [2:0] {Idle, AddrR, AddrW, DataW, RespR, RespB} state_e;

    state_e              state_q, state_d;
    logic [OwnerW-1:0]   owner_q, owner_d;
    logic                last_write_q, last_write_d;
    logic [NumHosts-1:0] req;
    logic [OwnerW-1:0]   winner;
    logic                winner_write;

    assign req = host_ar_valid_i | host_aw_valid_i;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [OwnerW-1:0] rr_ptr_q, rr_ptr_d;
    int                idx;

    // Descending offset so the nearest requester at or after the pointer is assigned last.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int k = NumHosts - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % int'(NumHosts);
            if (req[idx]) winner = OwnerW'(idx);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == Idle && |req) begin
            rr_ptr_d = (winner == OwnerW'(NumHosts - 1)) ? '0 : winner + OwnerW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NumHosts - 1; i >= 0; i--) begin
            if (req[i]) winner = OwnerW'(i);
        end
    end
`endif

    // A host offering both AR and AW alternates kinds via the global last_write flag.
    assign winner_write = host_aw_valid_i[winner] & (~host_ar_valid_i[winner] | ~last_write_q);

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        last_write_d      = last_write_q;
        host_ar_ready_o   = '0;
        host_aw_ready_o   = '0;
        host_w_ready_o    = '0;
        host_r_valid_o    = '0;
        host_b_valid_o    = '0;
        device_ar_valid_o = 1'b0;
        device_aw_valid_o = 1'b0;
        device_w_valid_o  = 1'b0;
        device_r_ready_o  = 1'b0;
        device_b_ready_o  = 1'b0;
        case (state_q)
            Idle: begin
                if (|req) begin
                    owner_d      = winner;
                    last_write_d = winner_write;
                    state_d      = winner_write ? AddrW : AddrR;
                end
            end
            AddrR: begin
                device_ar_valid_o        = host_ar_valid_i[owner_q];
                host_ar_ready_o[owner_q] = device_ar_ready_i;
                if (host_ar_valid_i[owner_q] && device_ar_ready_i) state_d = RespR;
            end
            AddrW: begin
                device_aw_valid_o        = host_aw_valid_i[owner_q];
                host_aw_ready_o[owner_q] = device_aw_ready_i;
                if (host_aw_valid_i[owner_q] && device_aw_ready_i) state_d = DataW;
            end
            DataW: begin
                device_w_valid_o        = host_w_valid_i[owner_q];
                host_w_ready_o[owner_q] = device_w_ready_i;
                if (host_w_valid_i[owner_q] && device_w_ready_i && host_w_last_i[owner_q]) begin
                    state_d = RespB;
                end
            end
            RespR: begin
                device_r_ready_o        = host_r_ready_i[owner_q];
                host_r_valid_o[owner_q] = device_r_valid_i;
                if (device_r_valid_i && host_r_ready_i[owner_q] && device_r_last_i) state_d = Idle;
            end
            RespB: begin
                device_b_ready_o        = host_b_ready_i[owner_q];
                host_b_valid_o[owner_q] = device_b_valid_i;
                if (device_b_valid_i && host_b_ready_i[owner_q]) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= Idle;
            owner_q      <= '0;
            last_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_write_q <= last_write_d;
        end
    end

    // Payloads follow the registered owner; only the per-host valids are gated.
    assign device_ar_id_o    = host_ar_id_i[owner_q];
    assign device_ar_addr_o  = host_ar_addr_i[owner_q];
    assign device_ar_len_o   = host_ar_len_i[owner_q];
    assign device_ar_size_o  = host_ar_size_i[owner_q];
    assign device_ar_burst_o = host_ar_burst_i[owner_q];
    assign device_aw_id_o    = host_aw_id_i[owner_q];
    assign device_aw_addr_o  = host_aw_addr_i[owner_q];
    assign device_aw_len_o   = host_aw_len_i[owner_q];
    assign device_aw_size_o  = host_aw_size_i[owner_q];
    assign device_aw_burst_o = host_aw_burst_i[owner_q];
    assign device_w_data_o   = host_w_data_i[owner_q];
    assign device_w_strb_o   = host_w_strb_i[owner_q];
    assign device_w_last_o   = host_w_last_i[owner_q];

    assign host_r_id_o   = device_r_id_i;
    assign host_r_data_o = device_r_data_i;
    assign host_r_resp_o = device_r_resp_i;
    assign host_r_last_o = device_r_last_i;
    assign host_r_user_o = 1'b0;
    assign host_b_id_o   = device_b_id_i;
    assign host_b_resp_o = device_b_resp_i;
    assign host_b_user_o = 1'b0;

    assign busy_o  = (state_q != Idle);
    assign owner_o = (state_q == Idle) ? '0 : owner_q;

    a_r_only_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        device_r_valid_i |-> state_q == RespR);
    a_b_only_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        device_b_valid_i |-> state_q == RespB);

endmodule

// File: tb/tb_axi_host_arbiter.sv
// Directed bench for axi_host_arbiter: inputs driven 1ns after posedge, outputs checked on negedge.
module tb_axi_host_arbiter;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic [1:0]        host_ar_valid_i, host_ar_ready_o;
    logic [1:0][0:0]   host_ar_id_i;
    logic [1:0][55:0]  host_ar_addr_i;
    logic [1:0][7:0]   host_ar_len_i;
    logic [1:0][2:0]   host_ar_size_i;
    logic [1:0][1:0]   host_ar_burst_i;
    logic [1:0]        host_aw_valid_i, host_aw_ready_o;
    logic [1:0][0:0]   host_aw_id_i;
    logic [1:0][55:0]  host_aw_addr_i;
    logic [1:0][7:0]   host_aw_len_i;
    logic [1:0][2:0]   host_aw_size_i;
    logic [1:0][1:0]   host_aw_burst_i;
    logic [1:0]        host_w_valid_i, host_w_ready_o;
    logic [1:0][63:0]  host_w_data_i;
    logic [1:0][7:0]   host_w_strb_i;
    logic [1:0]        host_w_last_i;
    logic [1:0]        host_r_valid_o, host_r_ready_i;
    logic [0:0]        host_r_id_o;
    logic [63:0]       host_r_data_o;
    logic [1:0]        host_r_resp_o;
    logic              host_r_last_o, host_r_user_o;
    logic [1:0]        host_b_valid_o, host_b_ready_i;
    logic [0:0]        host_b_id_o;
    logic [1:0]        host_b_resp_o;
    logic              host_b_user_o;
    logic              device_ar_valid_o, device_ar_ready_i;
    logic [0:0]        device_ar_id_o;
    logic [55:0]       device_ar_addr_o;
    logic [7:0]        device_ar_len_o;
    logic [2:0]        device_ar_size_o;
    logic [1:0]        device_ar_burst_o;
    logic              device_aw_valid_o, device_aw_ready_i;
    logic [0:0]        device_aw_id_o;
    logic [55:0]       device_aw_addr_o;
    logic [7:0]        device_aw_len_o;
    logic [2:0]        device_aw_size_o;
    logic [1:0]        device_aw_burst_o;
    logic              device_w_valid_o, device_w_ready_i;
    logic [63:0]       device_w_data_o;
    logic [7:0]        device_w_strb_o;
    logic              device_w_last_o;
    logic              device_r_valid_i, device_r_ready_o;
    logic [0:0]        device_r_id_i;
    logic [63:0]       device_r_data_i;
    logic [1:0]        device_r_resp_i;
    logic              device_r_last_i;
    logic              device_b_valid_i, device_b_ready_o;
    logic [0:0]        device_b_id_i;
    logic [1:0]        device_b_resp_i;
    logic              busy_o;
    logic [0:0]        owner_o;

    axi_host_arbiter #(.NumHosts(2), .IdWidth(1), .AddrWidth(56), .DataWidth(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_ar_valid_i(host_ar_valid_i), .host_ar_ready_o(host_ar_ready_o),
        .host_ar_id_i(host_ar_id_i), .host_ar_addr_i(host_ar_addr_i), .host_ar_len_i(host_ar_len_i),
        .host_ar_size_i(host_ar_size_i), .host_ar_burst_i(host_ar_burst_i),
        .host_aw_valid_i(host_aw_valid_i), .host_aw_ready_o(host_aw_ready_o),
        .host_aw_id_i(host_aw_id_i), .host_aw_addr_i(host_aw_addr_i), .host_aw_len_i(host_aw_len_i),
        .host_aw_size_i(host_aw_size_i), .host_aw_burst_i(host_aw_burst_i),
        .host_w_valid_i(host_w_valid_i), .host_w_ready_o(host_w_ready_o),
        .host_w_data_i(host_w_data_i), .host_w_strb_i(host_w_strb_i), .host_w_last_i(host_w_last_i),
        .host_r_valid_o(host_r_valid_o), .host_r_ready_i(host_r_ready_i), .host_r_id_o(host_r_id_o),
        .host_r_data_o(host_r_data_o), .host_r_resp_o(host_r_resp_o), .host_r_last_o(host_r_last_o),
        .host_r_user_o(host_r_user_o),
        .host_b_valid_o(host_b_valid_o), .host_b_ready_i(host_b_ready_i), .host_b_id_o(host_b_id_o),
        .host_b_resp_o(host_b_resp_o), .host_b_user_o(host_b_user_o),
        .device_ar_valid_o(device_ar_valid_o), .device_ar_ready_i(device_ar_ready_i),
        .device_ar_id_o(device_ar_id_o), .device_ar_addr_o(device_ar_addr_o), .device_ar_len_o(device_ar_len_o),
        .device_ar_size_o(device_ar_size_o), .device_ar_burst_o(device_ar_burst_o),
        .device_aw_valid_o(device_aw_valid_o), .device_aw_ready_i(device_aw_ready_i),
        .device_aw_id_o(device_aw_id_o), .device_aw_addr_o(device_aw_addr_o), .device_aw_len_o(device_aw_len_o),
        .device_aw_size_o(device_aw_size_o), .device_aw_burst_o(device_aw_burst_o),
        .device_w_valid_o(device_w_valid_o), .device_w_ready_i(device_w_ready_i),
        .device_w_data_o(device_w_data_o), .device_w_strb_o(device_w_strb_o), .device_w_last_o(device_w_last_o),
        .device_r_valid_i(device_r_valid_i), .device_r_ready_o(device_r_ready_o), .device_r_id_i(device_r_id_i),
        .device_r_data_i(device_r_data_i), .device_r_resp_i(device_r_resp_i), .device_r_last_i(device_r_last_i),
        .device_b_valid_i(device_b_valid_i), .device_b_ready_o(device_b_ready_o), .device_b_id_i(device_b_id_i),
        .device_b_resp_i(device_b_resp_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Log of W beats that will handshake on the coming posedge.
    logic [63:0] w_log[$];
    always @(negedge clk_i) begin
        if (rst_ni && device_w_valid_o && device_w_ready_i) w_log.push_back(device_w_data_o);
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        host_ar_valid_i = '0; host_ar_id_i = '0; host_ar_addr_i = '0; host_ar_len_i = '0;
        host_ar_size_i = '0; host_ar_burst_i = '0;
        host_aw_valid_i = '0; host_aw_id_i = '0; host_aw_addr_i = '0; host_aw_len_i = '0;
        host_aw_size_i = '0; host_aw_burst_i = '0;
        host_w_valid_i = '0; host_w_data_i = '0; host_w_strb_i = '0; host_w_last_i = '0;
        host_r_ready_i = '0; host_b_ready_i = '0;
        device_ar_ready_i = 1'b0; device_aw_ready_i = 1'b0; device_w_ready_i = 1'b0;
        device_r_valid_i = 1'b0; device_r_id_i = '0; device_r_data_i = '0; device_r_resp_i = '0;
        device_r_last_i = 1'b0;
        device_b_valid_i = 1'b0; device_b_id_i = '0; device_b_resp_i = '0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    int   exp_order [8];
    int   rem [2];
    int   w0;
    logic gb;

    initial begin
        rst_ni = 1'b0;
        clear_inputs();

        // Reset state
        @(negedge clk_i);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_owner", 64'(owner_o), 64'd0);
        check_eq("rst_dev_valids", 64'({device_ar_valid_o, device_aw_valid_o, device_w_valid_o}), 64'd0);
        check_eq("rst_dev_readies", 64'({device_r_ready_o, device_b_ready_o}), 64'd0);
        check_eq("rst_host_readies", 64'({host_ar_ready_o, host_aw_ready_o, host_w_ready_o}), 64'd0);
        check_eq("rst_host_valids", 64'({host_r_valid_o, host_b_valid_o}), 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single read from host1 with a 2-cycle AR stall and 4 R beats
        host_ar_valid_i[1] = 1'b1; host_ar_addr_i[1] = 56'h8000_0040;
        host_ar_len_i[1] = 8'd3; host_ar_id_i[1] = 1'b1;
        @(negedge clk_i);
        check_eq("rd_no_comb_path", 64'(device_ar_valid_o), 64'd0);
        cyc();
        @(negedge clk_i);
        check_eq("rd_ar_valid", 64'(device_ar_valid_o), 64'd1);
        check_eq("rd_ar_addr", 64'(device_ar_addr_o), 64'h8000_0040);
        check_eq("rd_ar_len", 64'(device_ar_len_o), 64'd3);
        check_eq("rd_ar_id", 64'(device_ar_id_o), 64'd1);
        check_eq("rd_owner", 64'(owner_o), 64'd1);
        check_eq("rd_busy", 64'(busy_o), 64'd1);
        check_eq("rd_ar_ready_stall", 64'(host_ar_ready_o), 64'd0);
        cyc();
        cyc();
        device_ar_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("rd_ar_ready_owner", 64'(host_ar_ready_o), 64'b10);
        cyc();
        host_ar_valid_i[1] = 1'b0; device_ar_ready_i = 1'b0; host_r_ready_i = 2'b11;
        for (int b = 0; b < 4; b++) begin
            device_r_valid_i = 1'b1; device_r_id_i = 1'b1;
            device_r_data_i = 64'hD000 + 64'(b); device_r_last_i = (b == 3);
            @(negedge clk_i);
            check_eq($sformatf("rd_r_valid%0d", b), 64'(host_r_valid_o), 64'b10);
            check_eq($sformatf("rd_r_data%0d", b), host_r_data_o, 64'hD000 + 64'(b));
            check_eq($sformatf("rd_r_id%0d", b), 64'(host_r_id_o), 64'd1);
            cyc();
        end
        check_eq("rd_r_user", 64'(host_r_user_o), 64'd0);
        device_r_valid_i = 1'b0; device_r_last_i = 1'b0;
        @(negedge clk_i);
        check_eq("rd_busy_fall", 64'(busy_o), 64'd0);

        // Write from host0 with 3 cycles of W backpressure
        apply_reset();
        w0 = w_log.size();
        host_aw_valid_i[0] = 1'b1; host_aw_addr_i[0] = 56'h1000; host_aw_len_i[0] = 8'd1;
        host_w_valid_i[0] = 1'b1; host_w_data_i[0] = 64'hA5A5_0000_0000_0001;
        host_w_strb_i[0] = 8'hFF; host_w_last_i[0] = 1'b0;
        device_aw_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("wr_idle_w_ready", 64'(host_w_ready_o), 64'd0);
        cyc();
        @(negedge clk_i);
        check_eq("wr_aw_valid", 64'(device_aw_valid_o), 64'd1);
        check_eq("wr_w_before_aw", 64'(device_w_valid_o), 64'd0);
        check_eq("wr_aw_ready", 64'(host_aw_ready_o), 64'b01);
        cyc();
        host_aw_valid_i[0] = 1'b0; device_aw_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check_eq("wr_bp_w_valid", 64'(device_w_valid_o), 64'd1);
            check_eq("wr_bp_w_ready", 64'(host_w_ready_o), 64'd0);
            cyc();
        end
        device_w_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("wr_w_ready", 64'(host_w_ready_o), 64'b01);
        cyc();
        host_w_data_i[0] = 64'hA5A5_0000_0000_0002; host_w_last_i[0] = 1'b1;
        @(negedge clk_i);
        check_eq("wr_w_last", 64'(device_w_last_o), 64'd1);
        cyc();
        host_w_valid_i[0] = 1'b0; host_w_last_i[0] = 1'b0; device_w_ready_i = 1'b0;
        device_b_valid_i = 1'b1; host_b_ready_i = 2'b11;
        @(negedge clk_i);
        check_eq("wr_b_route", 64'(host_b_valid_o), 64'b01);
        check_eq("wr_b_ready", 64'(device_b_ready_o), 64'd1);
        check_eq("wr_b_user", 64'(host_b_user_o), 64'd0);
        cyc();
        device_b_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("wr_idle", 64'(busy_o), 64'd0);
        check_eq("wr_beats", 64'(w_log.size() - w0), 64'd2);
        check_eq("wr_beat0", w_log[w0], 64'hA5A5_0000_0000_0001);
        check_eq("wr_beat1", w_log[w0 + 1], 64'hA5A5_0000_0000_0002);

        // Contention: both hosts issue 4 single-beat reads
        apply_reset();
        for (int t = 0; t < 8; t++) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
            exp_order[t] = t % 2;
`else
            exp_order[t] = (t < 4) ? 0 : 1;
`endif
        end
        rem[0] = 4; rem[1] = 4;
        host_ar_valid_i = 2'b11; host_ar_id_i[0] = 1'b0; host_ar_id_i[1] = 1'b1;
        host_ar_addr_i[0] = 56'h100; host_ar_addr_i[1] = 56'h200;
        device_ar_ready_i = 1'b1; host_r_ready_i = 2'b11;
        for (int t = 0; t < 8; t++) begin
            gb = 1'(exp_order[t]);
            @(negedge clk_i);
            cyc();
            @(negedge clk_i);
            check_eq($sformatf("cont_owner%0d", t), 64'(owner_o), 64'(gb));
            check_eq($sformatf("cont_ar_id%0d", t), 64'(device_ar_id_o), 64'(gb));
            cyc();
            rem[gb] = rem[gb] - 1;
            if (rem[gb] == 0) host_ar_valid_i[gb] = 1'b0;
            device_r_valid_i = 1'b1; device_r_last_i = 1'b1; device_r_id_i = gb;
            device_r_data_i = 64'(t);
            @(negedge clk_i);
            check_eq($sformatf("cont_r_route%0d", t), 64'(host_r_valid_o), 64'(1) << gb);
            cyc();
            device_r_valid_i = 1'b0; device_r_last_i = 1'b0;
        end

        // Same host offers AR and AW from reset: write first, then read
        apply_reset();
        host_ar_valid_i[0] = 1'b1; host_ar_addr_i[0] = 56'h2000;
        host_aw_valid_i[0] = 1'b1; host_aw_addr_i[0] = 56'h3000;
        device_aw_ready_i = 1'b1; device_ar_ready_i = 1'b1; device_w_ready_i = 1'b1;
        @(negedge clk_i);
        cyc();
        @(negedge clk_i);
        check_eq("both_first_aw", 64'(device_aw_valid_o), 64'd1);
        check_eq("both_first_not_ar", 64'(device_ar_valid_o), 64'd0);
        cyc();
        host_aw_valid_i[0] = 1'b0;
        host_w_valid_i[0] = 1'b1; host_w_data_i[0] = 64'h55; host_w_last_i[0] = 1'b1;
        cyc();
        host_w_valid_i[0] = 1'b0; host_w_last_i[0] = 1'b0;
        device_b_valid_i = 1'b1; host_b_ready_i[0] = 1'b1;
        cyc();
        device_b_valid_i = 1'b0;
        @(negedge clk_i);
        cyc();
        @(negedge clk_i);
        check_eq("both_then_ar", 64'(device_ar_valid_o), 64'd1);
        check_eq("both_then_ar_addr", 64'(device_ar_addr_o), 64'h2000);
        check_eq("both_then_not_aw", 64'(device_aw_valid_o), 64'd0);
        cyc();
        host_ar_valid_i[0] = 1'b0;
        device_r_valid_i = 1'b1; device_r_last_i = 1'b1; host_r_ready_i[0] = 1'b1;
        cyc();
        device_r_valid_i = 1'b0; device_r_last_i = 1'b0;
        @(negedge clk_i);
        check_eq("both_idle", 64'(busy_o), 64'd0);

        // Early W from host0 while host1's read holds the grant
        apply_reset();
        w0 = w_log.size();
        host_ar_valid_i[1] = 1'b1; host_ar_addr_i[1] = 56'h4000; host_ar_id_i[1] = 1'b1;
        device_ar_ready_i = 1'b1; device_w_ready_i = 1'b1;
        @(negedge clk_i);
        cyc();
        host_w_valid_i[0] = 1'b1; host_w_data_i[0] = 64'hCAFE_F00D_1234_5678;
        host_w_strb_i[0] = 8'hFF; host_w_last_i[0] = 1'b1;
        @(negedge clk_i);
        check_eq("early_owner1", 64'(owner_o), 64'd1);
        check_eq("early_w_ready_ar", 64'(host_w_ready_o), 64'd0);
        check_eq("early_w_valid_ar", 64'(device_w_valid_o), 64'd0);
        cyc();
        host_ar_valid_i[1] = 1'b0;
        host_aw_valid_i[0] = 1'b1; host_aw_addr_i[0] = 56'h5000;
        device_r_valid_i = 1'b1; device_r_last_i = 1'b1; device_r_id_i = 1'b1; host_r_ready_i[1] = 1'b1;
        @(negedge clk_i);
        check_eq("early_w_ready_r", 64'(host_w_ready_o), 64'd0);
        cyc();
        device_r_valid_i = 1'b0; device_r_last_i = 1'b0;
        @(negedge clk_i);
        check_eq("early_w_ready_idle", 64'(host_w_ready_o), 64'd0);
        cyc();
        @(negedge clk_i);
        check_eq("early_owner0", 64'(owner_o), 64'd0);
        check_eq("early_aw_valid", 64'(device_aw_valid_o), 64'd1);
        check_eq("early_w_valid_aw", 64'(device_w_valid_o), 64'd0);
        cyc();
        device_aw_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("early_w_ready_aw", 64'(host_w_ready_o), 64'd0);
        cyc();
        host_aw_valid_i[0] = 1'b0; device_aw_ready_i = 1'b0;
        @(negedge clk_i);
        check_eq("early_w_ready_dw", 64'(host_w_ready_o), 64'b01);
        check_eq("early_w_data", device_w_data_o, 64'hCAFE_F00D_1234_5678);
        cyc();
        host_w_valid_i[0] = 1'b0; host_w_last_i[0] = 1'b0;
        device_b_valid_i = 1'b1; host_b_ready_i[0] = 1'b1;
        cyc();
        device_b_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("early_idle", 64'(busy_o), 64'd0);
        check_eq("early_beats", 64'(w_log.size() - w0), 64'd1);
        check_eq("early_logged", w_log[w0], 64'hCAFE_F00D_1234_5678);

        // Reset in the middle of a 4-beat write burst
        apply_reset();
        host_aw_valid_i[0] = 1'b1; host_aw_len_i[0] = 8'd3; host_aw_addr_i[0] = 56'h6000;
        device_aw_ready_i = 1'b1; device_w_ready_i = 1'b1;
        @(negedge clk_i);
        cyc();
        cyc();
        host_aw_valid_i[0] = 1'b0;
        host_w_valid_i[0] = 1'b1; host_w_data_i[0] = 64'd1; host_w_last_i[0] = 1'b0;
        @(negedge clk_i);
        check_eq("rstdw_w_valid", 64'(device_w_valid_o), 64'd1);
        cyc();
        host_w_data_i[0] = 64'd2;
        rst_ni = 1'b0;
        #1;
        check_eq("rstdw_w_valid0", 64'(device_w_valid_o), 64'd0);
        check_eq("rstdw_w_ready0", 64'(host_w_ready_o), 64'd0);
        check_eq("rstdw_busy", 64'(busy_o), 64'd0);
        check_eq("rstdw_owner", 64'(owner_o), 64'd0);
        check_eq("rstdw_aw_valid", 64'(device_aw_valid_o), 64'd0);
        clear_inputs();
        cyc();
        rst_ni = 1'b1;
        host_ar_valid_i[1] = 1'b1; host_ar_addr_i[1] = 56'h7000; host_ar_id_i[1] = 1'b1;
        device_ar_ready_i = 1'b1;
        @(negedge clk_i);
        cyc();
        @(negedge clk_i);
        check_eq("rstdw_fresh_ar", 64'(device_ar_valid_o), 64'd1);
        check_eq("rstdw_fresh_owner", 64'(owner_o), 64'd1);
        cyc();
        host_ar_valid_i[1] = 1'b0;
        device_r_valid_i = 1'b1; device_r_last_i = 1'b1; device_r_id_i = 1'b1; host_r_ready_i[1] = 1'b1;
        cyc();
        device_r_valid_i = 1'b0; device_r_last_i = 1'b0;
        @(negedge clk_i);
        check_eq("rstdw_fresh_done", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
